gray_conv_sched: RTL and testbench
==================================

// Module: gray_conv_sched
// PURPOSE
//  Shares one bit-serial Gray-to-binary conversion engine between two requesters.
//  A round-robin arbiter grants one request at a time; the engine resolves one bit per clock, MSB first.
//  The result is returned on a single valid/ready response channel tagged with the requester id.
//  Sits between pointer/counter producers and the consumers that need binary values.
// PARAMETERS
//  WIDTH   4   code width in bits; legal range 2..32
// PORTS
//  clk         in   1      single clock; all state changes on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  req0_valid  in   1      requester 0 has a code to convert
//  req0_ready  out  1      requester 0 code accepted this cycle (valid&ready)
//  req0_gray   in   WIDTH  requester 0 Gray code
//  req1_valid  in   1      requester 1 has a code to convert
//  req1_ready  out  1      requester 1 code accepted this cycle
//  req1_gray   in   WIDTH  requester 1 Gray code
//  rsp_valid   out  1      rsp_bin/rsp_id hold a finished result
//  rsp_ready   in   1      consumer takes the result this cycle
//  rsp_bin     out  WIDTH  converted binary value
//  rsp_id      out  1      0 = result for requester 0, 1 = requester 1
//  busy        out  1      engine not IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rsp_valid=0, rsp_bin=0, rsp_id=0, busy=0, both ready=0.
//    Any in-flight conversion is discarded. Round-robin priority returns to requester 0.
//  FSM: IDLE -> CONV -> DONE -> IDLE.
//  IDLE: reqN_ready is combinational. It goes high only for the granted requester, only while its valid is high.
//    Grant rule: only one valid -> that one.
//    Both valid -> the one not granted last. First grant after reset goes to requester 0.
//    Handshake in cycle k: capture gray, capture id, clear rsp_bin, update last-grant, go to CONV.
//  CONV: WIDTH cycles, k+1..k+WIDTH. Bit index i starts at WIDTH-1 and decrements.
//    Each cycle computes rsp_bin[i] = g[i] ^ rsp_bin[i+1], with rsp_bin[WIDTH] taken as 0.
//    The last cycle, i=0, goes to DONE.
//  DONE: rsp_valid=1 from cycle k+WIDTH+1. rsp_bin and rsp_id stay stable until rsp_ready=1.
//    On rsp_valid&rsp_ready: go to IDLE. rsp_valid drops next cycle; rsp_bin keeps its value.
//  Throughput: one result per WIDTH+2 cycles at best. The next accept is possible in the first IDLE cycle.
//  In CONV and DONE, both reqN_ready=0.
//    Requester inputs are sampled only at the handshake.
//    A valid dropped before ready has no effect and needs no recovery.
//  A valid held through another requester's service keeps its priority claim.
//    Under contention, no requester waits more than one full service.
//  rsp_ready outside DONE is ignored. busy=1 in CONV and DONE.
//  Width rules: index counter is clog2(WIDTH) bits. No arithmetic overflow paths exist.
// CONFIGURATION
//  GRAY_CONV_DIR_EN defined:
//    Adds ports req0_dir and req1_dir (in, 1), captured with the code at the handshake.
//    dir=0: Gray->binary as above.
//    dir=1: binary->Gray, computing rsp_bin[i] = g[i] ^ g[i+1], with g[WIDTH] taken as 0.
//    dir=1 uses the same CONV schedule, so latency is identical.
//  GRAY_CONV_DIR_EN undefined: dir ports are absent; Gray->binary only.
// TESTING (WIDTH=4)
//  1. req0_gray=4'b0110, rsp_ready=1 -> req0_ready in the accept cycle; rsp_bin=4'b0100 with rsp_id=0, 5 cycles later.
//  2. After reset, req0=4'b0110 and req1=4'b1000 both valid in the same cycle.
//     -> req0 served first (4'b0100, id0), then req1 (4'b1111, id1).
//     Next contention grants req0.
//  3. rsp_ready=0 for 6 cycles in DONE -> rsp_valid, rsp_bin and rsp_id held; both ready=0.
//     Result taken on the first rsp_ready=1 cycle.
//  4. rst_n=0 in the 2nd CONV cycle -> all outputs 0 at once. After release, no rsp_valid appears.
//     A new contention is granted to req0.
//  5. Sweep all 16 codes on each port. Check rsp_bin equals the reference Gray-to-binary value and rsp_id matches the port.
//  6. With GRAY_CONV_DIR_EN: req1_gray=4'b0100, req1_dir=1 -> rsp_bin=4'b0110, id1, same latency as test 1.

Source files
------------

// File: rtl/gray_conv_sched.sv
// gray_conv_sched
//   Shares one bit-serial Gray-to-binary conversion engine between two
//   requesters. A round-robin arbiter grants one request at a time. The engine
//   resolves one bit per clock, MSB first. The result is returned on a single
//   valid/ready response channel, tagged with the requester id.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req0_valid/ready/gray  requester 0 code channel (ready is combinational)
//   req1_valid/ready/gray  requester 1 code channel (ready is combinational)
//   rsp_valid/ready        response handshake
//   rsp_bin, rsp_id        converted value and originating requester
//   busy                   engine is converting or holding a result
//
// Build option
//   GRAY_CONV_DIR_EN adds req0_dir/req1_dir. These are captured with the code.
//   dir=1 selects binary->Gray on the same schedule. Without the macro the
//   block converts Gray->binary only.
//
// state  | meaning
// IDLE   | waiting for a request; the granted requester sees ready
// CONV   | resolving one result bit per cycle, MSB down to bit 0
// DONE   | result presented on rsp_*, held until rsp_ready
module gray_conv_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_gray,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_gray,
`ifdef GRAY_CONV_DIR_EN
  input  logic             req0_dir,
  input  logic             req1_dir,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_bin,
  output logic             rsp_id,
  output logic             busy
);

  localparam int IDXW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             id_q, id_d;
  logic             prev_q, prev_d;
  logic             last_q, last_d;
`ifdef GRAY_CONV_DIR_EN
  logic             dir_q, dir_d;
`endif

  logic gnt0, gnt1;
  logic conv_bit;

  // Under contention the requester that was not served last wins.
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);
  assign gnt0 = req0_valid & ~gnt1;

  // Ready is also gated by rst_n, so it stays low while reset is asserted.
  assign req0_ready = rst_n & (state_q == S_IDLE) & gnt0;
  assign req1_ready = rst_n & (state_q == S_IDLE) & gnt1;

  assign rsp_valid = (state_q == S_DONE);
  assign rsp_bin   = bin_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    gray_d   = gray_q;
    bin_d    = bin_q;
    idx_d    = idx_q;
    id_d     = id_q;
    prev_d   = prev_q;
    last_d   = last_q;
`ifdef GRAY_CONV_DIR_EN
    dir_d    = dir_q;
`endif
    // prev_q carries the bit above the current index. In Gray->binary it is
    // the previous result bit. In binary->Gray it is the previous input bit.
    // Either way it is 0 for the MSB.
    conv_bit = gray_q[idx_q] ^ prev_q;

    case (state_q)
      S_IDLE: begin
        if (gnt0 | gnt1) begin
          gray_d  = gnt1 ? req1_gray : req0_gray;
          id_d    = gnt1;
          last_d  = gnt1;
          bin_d   = '0;
          idx_d   = IDXW'(WIDTH - 1);
          prev_d  = 1'b0;
`ifdef GRAY_CONV_DIR_EN
          dir_d   = gnt1 ? req1_dir : req0_dir;
`endif
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        bin_d[idx_q] = conv_bit;
`ifdef GRAY_CONV_DIR_EN
        prev_d = dir_q ? gray_q[idx_q] : conv_bit;
`else
        prev_d = conv_bit;
`endif
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gray_q  <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
      id_q    <= 1'b0;
      prev_q  <= 1'b0;
      // Reset as if requester 1 was served last, so requester 0 wins first.
      last_q  <= 1'b1;
`ifdef GRAY_CONV_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
`ifdef GRAY_CONV_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

endmodule

// File: tb/tb_gray_conv_sched.sv
`timescale 1ns/1ps
module tb_gray_conv_sched;

  localparam int W   = 4;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic         req1_valid = 1'b0;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] req0_gray = '0;
  logic [W-1:0] req1_gray = '0;
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [W-1:0] rsp_bin;
`ifdef GRAY_CONV_DIR_EN
  logic         req0_dir = 1'b0;
  logic         req1_dir = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit model_last = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gray_conv_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_gray  (req0_gray),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_gray  (req1_gray),
`ifdef GRAY_CONV_DIR_EN
    .req0_dir   (req0_dir),
    .req1_dir   (req1_dir),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_bin    (rsp_bin),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  // Reference: binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] v);
    return v ^ (v >> 1);
  endfunction

  function automatic bit ref_grant(input bit v0, input bit v1);
    if (v0 && v1) return !model_last;
    return v1 && !v0;
  endfunction

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (rsp_valid !== 1'b1) n = -1;
  endtask

  // Starts at a negedge in IDLE and ends at the negedge where rsp_valid is seen.
  task automatic run_conv(input bit port, input logic [W-1:0] code,
                          output logic [W-1:0] bin, output bit id,
                          output int lat, output bit acc);
    if (port) begin req1_valid = 1'b1; req1_gray = code; end
    else      begin req0_valid = 1'b1; req0_gray = code; end
    #1 acc = port ? (req1_ready === 1'b1) : (req0_ready === 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat);
    if (lat >= 0) lat = lat + 1;
    bin = rsp_bin;
    id  = rsp_id;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_bin !== '0) begin n_fail++; $display("FAIL reset_rsp_bin got=%b exp=0000", rsp_bin); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%b exp=0", rsp_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [W-1:0] b; bit id; int lat; bit acc;
    rsp_ready = 1'b1;
    run_conv(1'b0, 4'b0110, b, id, lat, acc);
    model_last = 1'b0;
    n_checks++; if (!acc) begin n_fail++; $display("FAIL basic_accept got=0 exp=1"); end
    n_checks++; if (b !== 4'b0100) begin n_fail++; $display("FAIL basic_bin got=%b exp=0100", b); end
    n_checks++; if (id !== 1'b0) begin n_fail++; $display("FAIL basic_id got=%b exp=0", id); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    @(negedge clk);
  endtask

  task automatic test_contention;
    int n; logic [W-1:0] g0;
    test_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_gray = 4'b0110;
    req1_valid = 1'b1; req1_gray = 4'b1000;
    #1;
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL cont_first_req0_ready got=%b exp=1", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL cont_first_req1_ready got=%b exp=0", req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL cont_conv_req1_ready got=%b exp=0", req1_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_conv_busy got=%b exp=1", busy); end
    wait_rsp(n);
    n_checks++; if (rsp_bin !== 4'b0100 || rsp_id !== 1'b0) begin n_fail++; $display("FAIL cont_rsp0 got=%b/%b exp=0100/0", rsp_bin, rsp_id); end
    model_last = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL cont_req1_ready got=%b exp=1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(n);
    n_checks++; if (rsp_bin !== 4'b1111 || rsp_id !== 1'b1) begin n_fail++; $display("FAIL cont_rsp1 got=%b/%b exp=1111/1", rsp_bin, rsp_id); end
    model_last = 1'b1;
    @(negedge clk);
    g0 = W'($urandom);
    req0_valid = 1'b1; req0_gray = g0;
    req1_valid = 1'b1; req1_gray = W'($urandom);
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL cont_next_grant got=%b%b exp=01", req1_ready, req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1'b0;
    wait_rsp(n);
    n_checks++; if (rsp_bin !== ref_g2b(g0) || rsp_id !== 1'b0) begin n_fail++; $display("FAIL cont_next_rsp got=%b/%b exp=%b/0", rsp_bin, rsp_id, ref_g2b(g0)); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic [W-1:0] b, code, exp_b; bit id; int lat; bit acc;
    rsp_ready = 1'b0;
    code = W'($urandom);
    exp_b = ref_g2b(code);
    run_conv(1'b0, code, b, id, lat, acc);
    model_last = 1'b0;
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
    req1_valid = 1'b1; req1_gray = W'($urandom);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc%0d got=%b exp=1", i, rsp_valid); end
      n_checks++; if (rsp_bin !== exp_b || rsp_id !== 1'b0) begin n_fail++; $display("FAIL bp_hold_data cyc%0d got=%b/%b exp=%b/0", i, rsp_bin, rsp_id, exp_b); end
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready cyc%0d got=%b%b exp=00", i, req1_ready, req0_ready); end
    end
    @(negedge clk);
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_take_valid got=%b exp=1", rsp_valid); end
    @(negedge clk);
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_bin !== exp_b) begin n_fail++; $display("FAIL bp_after_bin got=%b exp=%b", rsp_bin, exp_b); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_after_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    int n; bit seen; logic [W-1:0] g0;
    rsp_ready = 1'b1;
    req1_valid = 1'b1; req1_gray = 4'b1000;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_accept got=%b exp=1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || rsp_id !== 1'b1) begin n_fail++; $display("FAIL rmid_pre busy/id got=%b/%b exp=1/1", busy, rsp_id); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_valid got=%b exp=0", rsp_valid); end
    n_checks++; if (rsp_bin !== '0) begin n_fail++; $display("FAIL rmid_rsp_bin got=%b exp=0000", rsp_bin); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp_id got=%b exp=0", rsp_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rmid_ghost_rsp got=1 exp=0"); end
    g0 = W'($urandom);
    req0_valid = 1'b1; req0_gray = g0;
    req1_valid = 1'b1; req1_gray = W'($urandom);
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_grant got=%b%b exp=01", req1_ready, req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    model_last = 1'b0;
    wait_rsp(n);
    n_checks++; if (rsp_bin !== ref_g2b(g0) || rsp_id !== 1'b0) begin n_fail++; $display("FAIL rmid_rsp got=%b/%b exp=%b/0", rsp_bin, rsp_id, ref_g2b(g0)); end
    @(negedge clk);
  endtask

  task automatic test_sweep;
    logic [W-1:0] b; bit id; int lat; bit acc;
    rsp_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < (1 << W); c++) begin
        run_conv(p[0], W'(c), b, id, lat, acc);
        model_last = p[0];
        n_checks++; if (!acc) begin n_fail++; $display("FAIL sweep_accept port%0d code%0d got=0 exp=1", p, c); end
        n_checks++; if (b !== ref_g2b(W'(c))) begin n_fail++; $display("FAIL sweep_bin port%0d got=%b exp=%b", p, b, ref_g2b(W'(c))); end
        n_checks++; if (id !== p[0]) begin n_fail++; $display("FAIL sweep_id port%0d code%0d got=%b exp=%b", p, c, id, p[0]); end
        n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL sweep_latency port%0d code%0d got=%0d exp=%0d", p, c, lat, LAT); end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] served; bit exp_id; int n, lat, prev_cyc;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_gray = W'($urandom);
    req1_valid = 1'b1; req1_gray = W'($urandom);
    prev_cyc = -1;
    for (int s = 0; s < 4; s++) begin
      exp_id = ref_grant(1'b1, 1'b1);
      n = 0;
      #1;
      while (!(req0_ready === 1'b1 || req1_ready === 1'b1) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      n_checks++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin n_fail++; $display("FAIL b2b_grant svc%0d got=%b%b exp_id=%b", s, req1_ready, req0_ready, exp_id); end
      if (s > 0) begin
        n_checks++; if (cyc - prev_cyc != W + 2) begin n_fail++; $display("FAIL b2b_spacing svc%0d got=%0d exp=%0d", s, cyc - prev_cyc, W + 2); end
      end
      prev_cyc = cyc;
      served = exp_id ? req1_gray : req0_gray;
      @(negedge clk);
      // Inputs change right after the handshake; only the captured code counts.
      if (exp_id) req1_gray = W'($urandom); else req0_gray = W'($urandom);
      wait_rsp(lat);
      if (lat >= 0) lat = lat + 1;
      n_checks++; if (rsp_bin !== ref_g2b(served) || rsp_id !== exp_id) begin n_fail++; $display("FAIL b2b_rsp svc%0d got=%b/%b exp=%b/%b", s, rsp_bin, rsp_id, ref_g2b(served), exp_id); end
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL b2b_latency svc%0d got=%0d exp=%0d", s, lat, LAT); end
      model_last = exp_id;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [1:0] r; logic [W-1:0] g0, g1, served; bit exp_id; int lat, stall;
    for (int it = 0; it < 30; it++) begin
      r = 2'($urandom_range(1, 3));
      g0 = W'($urandom); g1 = W'($urandom);
      exp_id = ref_grant(r[0], r[1]);
      served = exp_id ? g1 : g0;
      rsp_ready = 1'b0;
      req0_valid = r[0]; req0_gray = g0;
      req1_valid = r[1]; req1_gray = g1;
      #1;
      n_checks++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin n_fail++; $display("FAIL rnd_grant it%0d v=%b got=%b%b exp_id=%b", it, r, req1_ready, req0_ready, exp_id); end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_rsp(lat);
      if (lat >= 0) lat = lat + 1;
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd_latency it%0d got=%0d exp=%0d", it, lat, LAT); end
      stall = $urandom_range(0, 3);
      repeat (stall) @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      n_checks++; if (rsp_valid !== 1'b1 || rsp_bin !== ref_g2b(served) || rsp_id !== exp_id) begin n_fail++; $display("FAIL rnd_rsp it%0d got=%b/%b/%b exp=1/%b/%b", it, rsp_valid, rsp_bin, rsp_id, ref_g2b(served), exp_id); end
      model_last = exp_id;
      @(negedge clk);
    end
  endtask

`ifdef GRAY_CONV_DIR_EN
  task automatic test_dir;
    logic [W-1:0] b, code; bit id; int lat; bit acc;
    rsp_ready = 1'b1;
    req1_dir = 1'b1;
    run_conv(1'b1, 4'b0100, b, id, lat, acc);
    model_last = 1'b1;
    n_checks++; if (!acc || b !== 4'b0110 || id !== 1'b1) begin n_fail++; $display("FAIL dir_fixed got=%b/%b/%b exp=1/0110/1", acc, b, id); end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir_latency got=%0d exp=%0d", lat, LAT); end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      code = W'($urandom);
      req0_dir = i[0]; req1_dir = i[0];
      run_conv(i[1], code, b, id, lat, acc);
      model_last = i[1];
      n_checks++; if (b !== (i[0] ? ref_b2g(code) : ref_g2b(code)) || id !== i[1]) begin n_fail++; $display("FAIL dir_rnd%0d got=%b/%b", i, b, id); end
      @(negedge clk);
    end
    req0_dir = 1'b0; req1_dir = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    test_back_to_back();
    test_random();
`ifdef GRAY_CONV_DIR_EN
    test_dir();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
